// File: rtl/matmul_mem_responder_pkg.sv
// Shared definitions for the matmul/pooling memory responder: default
// geometry, bank window bases, the out-of-window read pattern and the
// host access FSM encoding.
package matmul_mem_responder_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_BANK_DEPTH = 4;
   localparam int DEF_C_WRITES   = 2;

   localparam logic [DEF_ADDR_W-1:0] DEF_BASE_A = 10'h000;
   localparam logic [DEF_ADDR_W-1:0] DEF_BASE_B = 10'h100;
   localparam logic [DEF_ADDR_W-1:0] DEF_BASE_C = 10'h200;

   localparam logic [DEF_DATA_W-1:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

   // Host access FSM: wait for an idle accelerator, perform the access, ack.
   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_WAIT = 2'd1,
      H_ACK  = 2'd2
   } host_state_t;

endpackage

// File: rtl/matmul_mem_responder_bank.sv
// One word bank of the responder: DEPTH registers cleared by reset, one
// combinational read port and one write port, each with its own window
// decode so the parent can tell hits from out-of-window accesses.
module mm_bank
   import matmul_mem_responder_pkg::*;
#(
   parameter int                DATA_W = DEF_DATA_W,
   parameter int                ADDR_W = DEF_ADDR_W,
   parameter int                DEPTH  = DEF_BANK_DEPTH,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_hit,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_hit
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];

   // One extra bit catches addresses below BASE as a borrow.
   logic [ADDR_W:0]   rd_off;
   logic [ADDR_W:0]   wr_off;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;

   assign rd_off = {1'b0, rd_addr} - {1'b0, BASE};
   assign wr_off = {1'b0, wr_addr} - {1'b0, BASE};
   assign rd_hit = !rd_off[ADDR_W] && (rd_off[ADDR_W-1:0] < ADDR_W'(DEPTH));
   assign wr_hit = !wr_off[ADDR_W] && (wr_off[ADDR_W-1:0] < ADDR_W'(DEPTH));
   assign rd_idx = rd_off[IDX_W-1:0];
   assign wr_idx = wr_off[IDX_W-1:0];

   assign rd_data = mem[rd_idx];

   // Word storage: cleared on reset, written only when the write lands in this window.
   // NOTE: the storage is deliberately in the async reset -- banks must read back zero after rstn, so this cannot map onto a reset-less RAM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && wr_hit) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/matmul_mem_responder.sv
// Memory-side responder for the matmul/pooling accelerator. Serves the A and
// B read ports, absorbs C writes, counts C writes into jobs, and lets a host
// preload/read back the banks whenever the accelerator is idle and quiet.
module matmul_mem_responder
   import matmul_mem_responder_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter int                BANK_DEPTH = DEF_BANK_DEPTH,
   parameter logic [ADDR_W-1:0] BASE_A     = DEF_BASE_A,
   parameter logic [ADDR_W-1:0] BASE_B     = DEF_BASE_B,
   parameter logic [ADDR_W-1:0] BASE_C     = DEF_BASE_C,
   parameter int                C_WRITES   = DEF_C_WRITES,
   parameter logic [DATA_W-1:0] ERR_DATA   = DEF_ERR_DATA
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              mem_read_en_A,
   input  logic [ADDR_W-1:0] mem_addr_A,
   output logic [DATA_W-1:0] mem_data_A,
   input  logic              mem_read_en_B,
   input  logic [ADDR_W-1:0] mem_addr_B,
   output logic [DATA_W-1:0] mem_data_B,
   input  logic              mem_write_en_C,
   input  logic [ADDR_W-1:0] mem_addr_C,
   input  logic [DATA_W-1:0] mem_data_C,
   input  logic              acc_ready,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              result_done,
   output logic              addr_err,
   input  logic              err_clr
);

   localparam int               CNT_W   = $clog2(C_WRITES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_WRITES);

   host_state_t       state;
   host_state_t       state_nxt;
   logic              grant;
   logic              accel_busy;
   logic              acc_ready_q;
   logic              acc_fall;
   logic [CNT_W-1:0]  wr_cnt;
   logic              err_set;
   logic              host_hit;
   logic [DATA_W-1:0] host_rd_val;

   logic [ADDR_W-1:0] a_rd_addr, b_rd_addr, c_wr_addr;
   logic [DATA_W-1:0] a_rd_data, b_rd_data, c_rd_data, c_wr_data;
   logic              a_rd_hit, b_rd_hit, c_rd_hit;
   logic              a_wr_hit, b_wr_hit, c_wr_hit;
   logic              c_wr_en;

   // Accelerator strobes own the banks; the host only reaches them on a grant,
   // which requires every strobe to be low, so the muxes never collide.
   assign accel_busy = mem_read_en_A | mem_read_en_B | mem_write_en_C;
   assign a_rd_addr  = mem_read_en_A  ? mem_addr_A : host_addr;
   assign b_rd_addr  = mem_read_en_B  ? mem_addr_B : host_addr;
   assign c_wr_en    = mem_write_en_C | (grant & host_we);
   assign c_wr_addr  = mem_write_en_C ? mem_addr_C : host_addr;
   assign c_wr_data  = mem_write_en_C ? mem_data_C : host_wdata;

   mm_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(BANK_DEPTH), .BASE(BASE_A)) u_bank_a (
      .clk     (clk),
      .rstn    (rstn),
      .rd_addr (a_rd_addr),
      .rd_data (a_rd_data),
      .rd_hit  (a_rd_hit),
      .wr_en   (grant & host_we),
      .wr_addr (host_addr),
      .wr_data (host_wdata),
      .wr_hit  (a_wr_hit)
   );

   mm_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(BANK_DEPTH), .BASE(BASE_B)) u_bank_b (
      .clk     (clk),
      .rstn    (rstn),
      .rd_addr (b_rd_addr),
      .rd_data (b_rd_data),
      .rd_hit  (b_rd_hit),
      .wr_en   (grant & host_we),
      .wr_addr (host_addr),
      .wr_data (host_wdata),
      .wr_hit  (b_wr_hit)
   );

   mm_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(BANK_DEPTH), .BASE(BASE_C)) u_bank_c (
      .clk     (clk),
      .rstn    (rstn),
      .rd_addr (host_addr),
      .rd_data (c_rd_data),
      .rd_hit  (c_rd_hit),
      .wr_en   (c_wr_en),
      .wr_addr (c_wr_addr),
      .wr_data (c_wr_data),
      .wr_hit  (c_wr_hit)
   );

   // During a grant every bank port looks at host_addr, so the hit flags
   // directly tell which bank (if any) the host is addressing.
   assign host_hit    = host_we ? (a_wr_hit | b_wr_hit | c_wr_hit)
                                : (a_rd_hit | b_rd_hit | c_rd_hit);
   assign host_rd_val = a_rd_hit ? a_rd_data :
                        b_rd_hit ? b_rd_data :
                        c_rd_hit ? c_rd_data : ERR_DATA;

   assign err_set = (mem_read_en_A  && !a_rd_hit) ||
                    (mem_read_en_B  && !b_rd_hit) ||
                    (mem_write_en_C && !c_wr_hit) ||
                    (grant          && !host_hit);

   assign acc_fall = acc_ready_q && !acc_ready;

   // Host FSM state register; reset drops any transaction in flight without an ack.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= H_IDLE;
      end else begin
         // NOTE: every clocked process uses non-blocking assignments so all registers update from the same pre-edge values.
         state <= state_nxt;
      end
   end

   // Host FSM next state, grant and ack decode.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (which would infer a latch).
      state_nxt = state;
      grant     = 1'b0;
      host_ack  = 1'b0;
      case (state)
         H_IDLE: begin
            if (host_req) begin
               state_nxt = H_WAIT;
            end
         end
         H_WAIT: begin
            if (acc_ready && !accel_busy) begin
               grant     = 1'b1;
               state_nxt = H_ACK;
            end
         end
         H_ACK: begin
            host_ack  = 1'b1;
            state_nxt = H_IDLE;
         end
         default: state_nxt = H_IDLE;
      endcase
   end

   // Registered read data for accelerator ports A/B and the host; each holds until its next access.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_data_A <= '0;
         mem_data_B <= '0;
         host_rdata <= '0;
      end else begin
         if (mem_read_en_A) begin
            mem_data_A <= a_rd_hit ? a_rd_data : ERR_DATA;
         end
         if (mem_read_en_B) begin
            mem_data_B <= b_rd_hit ? b_rd_data : ERR_DATA;
         end
         if (grant && !host_we) begin
            host_rdata <= host_rd_val;
         end
      end
   end

   // Job tracking: count C strobes since acc_ready fell, pulse once on reaching C_WRITES.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_ready_q <= 1'b0;
         wr_cnt      <= '0;
         result_done <= 1'b0;
      end else begin
         acc_ready_q <= acc_ready;
         result_done <= mem_write_en_C && !acc_fall && (wr_cnt == CNT_MAX - CNT_W'(1));
         if (acc_fall) begin
            wr_cnt <= '0;
         end else if (mem_write_en_C && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
         end
      end
   end

   // Sticky out-of-window flag; a new miss wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr_err <= 1'b0;
      end else if (err_set) begin
         addr_err <= 1'b1;
      end else if (err_clr) begin
         addr_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matmul_mem_responder.sv
// Self-checking bench for matmul_mem_responder: directed sequences for the
// multi-cycle behaviour, a table of window-decode vectors, and a randomized
// run checked against a behavioural model of banks, job counter and host port.
module tb_matmul_mem_responder;
   import matmul_mem_responder_pkg::*;

   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam int          CW  = 2;

   logic        clk;
   logic        rstn;
   logic        mem_read_en_A, mem_read_en_B, mem_write_en_C;
   logic [9:0]  mem_addr_A, mem_addr_B, mem_addr_C;
   logic [31:0] mem_data_A, mem_data_B, mem_data_C;
   logic        acc_ready, host_req, host_we, host_ack;
   logic [9:0]  host_addr;
   logic [31:0] host_wdata, host_rdata;
   logic        result_done, addr_err, err_clr;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model state for the randomized run.
   logic [31:0] m_a [4];
   logic [31:0] m_b [4];
   logic [31:0] m_c [4];
   logic [31:0] m_da, m_db, m_rdata;
   logic        m_err, m_done, m_acc_prev;
   int          m_cnt;
   int          m_h;   // 0 idle, 1 waiting for grant, 2 acking

   typedef struct {
      logic        port_b;
      logic [9:0]  addr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   matmul_mem_responder dut (
      .clk            (clk),
      .rstn           (rstn),
      .mem_read_en_A  (mem_read_en_A),
      .mem_addr_A     (mem_addr_A),
      .mem_data_A     (mem_data_A),
      .mem_read_en_B  (mem_read_en_B),
      .mem_addr_B     (mem_addr_B),
      .mem_data_B     (mem_data_B),
      .mem_write_en_C (mem_write_en_C),
      .mem_addr_C     (mem_addr_C),
      .mem_data_C     (mem_data_C),
      .acc_ready      (acc_ready),
      .host_req       (host_req),
      .host_we        (host_we),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_ack       (host_ack),
      .host_rdata     (host_rdata),
      .result_done    (result_done),
      .addr_err       (addr_err),
      .err_clr        (err_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read_en_A  = 1'b0;
      mem_read_en_B  = 1'b0;
      mem_write_en_C = 1'b0;
      mem_addr_A     = '0;
      mem_addr_B     = '0;
      mem_addr_C     = '0;
      mem_data_C     = '0;
      host_req       = 1'b0;
      host_we        = 1'b0;
      host_addr      = '0;
      host_wdata     = '0;
      err_clr        = 1'b0;
   endtask

   // Full host transaction; lat counts edges from request to visible ack.
   task automatic host_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat);
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = addr;
      host_wdata = wdata;
      lat        = 0;
      do begin
         tick();
         lat++;
      end while (!host_ack && lat < 50);
      if (!host_ack) check("host_ack_timeout", 32'(host_ack), 32'd1);
      rdata    = host_rdata;
      host_req = 1'b0;
      host_we  = 1'b0;
      tick();
   endtask

   task automatic host_wr(input logic [9:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      int          lat;
      host_access(1'b1, addr, data, rd, lat);
   endtask

   task automatic host_rd_chk(input string name, input logic [9:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      int          lat;
      host_access(1'b0, addr, '0, rd, lat);
      check(name, rd, exp);
   endtask

   function automatic int win(input logic [9:0] addr, input int base);
      int off;
      off = int'(addr) - base;
      return (off >= 0 && off < 4) ? off : -1;
   endfunction

   function automatic logic [9:0] rnd_addr();
      case ($urandom_range(0, 3))
         0:       return 10'(32'h000 + $urandom_range(0, 5));
         1:       return 10'(32'h100 + $urandom_range(0, 5));
         2:       return 10'(32'h200 + $urandom_range(0, 5));
         default: return 10'($urandom);
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int   ia, ib, ic;
      logic busy, grant, set_err, fall;
      busy    = mem_read_en_A | mem_read_en_B | mem_write_en_C;
      grant   = (m_h == 1) && acc_ready && !busy;
      set_err = 1'b0;
      if (mem_read_en_A) begin
         ia = win(mem_addr_A, 'h000);
         if (ia >= 0) m_da = m_a[ia];
         else begin m_da = ERR; set_err = 1'b1; end
      end
      if (mem_read_en_B) begin
         ib = win(mem_addr_B, 'h100);
         if (ib >= 0) m_db = m_b[ib];
         else begin m_db = ERR; set_err = 1'b1; end
      end
      if (mem_write_en_C) begin
         ic = win(mem_addr_C, 'h200);
         if (ic >= 0) m_c[ic] = mem_data_C;
         else set_err = 1'b1;
      end
      if (grant) begin
         ia = win(host_addr, 'h000);
         ib = win(host_addr, 'h100);
         ic = win(host_addr, 'h200);
         if (ia >= 0) begin
            if (host_we) m_a[ia] = host_wdata; else m_rdata = m_a[ia];
         end else if (ib >= 0) begin
            if (host_we) m_b[ib] = host_wdata; else m_rdata = m_b[ib];
         end else if (ic >= 0) begin
            if (host_we) m_c[ic] = host_wdata; else m_rdata = m_c[ic];
         end else begin
            set_err = 1'b1;
            if (!host_we) m_rdata = ERR;
         end
      end
      fall   = m_acc_prev && !acc_ready;
      m_done = 1'b0;
      if (fall) m_cnt = 0;
      else if (mem_write_en_C && m_cnt < CW) begin
         m_cnt++;
         m_done = (m_cnt == CW);
      end
      m_acc_prev = acc_ready;
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      case (m_h)
         0:       if (host_req) m_h = 1;
         1:       if (grant) m_h = 2;
         default: m_h = 0;
      endcase
   endtask

   initial begin
      logic [31:0] rd;
      int          lat;
      int          acks;

      // ---------------- reset state ----------------
      clear_inputs();
      acc_ready = 1'b1;
      rstn      = 1'b0;
      repeat (3) tick();
      check("rst_data_A", mem_data_A, 32'd0);
      check("rst_data_B", mem_data_B, 32'd0);
      check("rst_host_ack", 32'(host_ack), 32'd0);
      check("rst_host_rdata", host_rdata, 32'd0);
      check("rst_result_done", 32'(result_done), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      rstn = 1'b1;
      tick();

      // ---------------- host write then read, latency 2 ----------------
      host_access(1'b1, 10'h000, 32'h0403_0201, rd, lat);
      check("p1_wr_latency", 32'(lat), 32'd2);
      host_access(1'b0, 10'h000, 32'h0, rd, lat);
      check("p1_rd_latency", 32'(lat), 32'd2);
      check("p1_rd_data", rd, 32'h0403_0201);

      // ---------------- port A read, latency 1, held ----------------
      host_wr(10'h001, 32'h0101_0101);
      mem_read_en_A = 1'b1;
      mem_addr_A    = 10'h001;
      tick();
      mem_read_en_A = 1'b0;
      mem_addr_A    = 10'h000;
      check("p2_read_A", mem_data_A, 32'h0101_0101);
      tick();
      tick();
      check("p2_hold_A", mem_data_A, 32'h0101_0101);

      // ---------------- job of two C writes ----------------
      acc_ready = 1'b0;
      tick();
      mem_write_en_C = 1'b1;
      mem_addr_C     = 10'h200;
      mem_data_C     = 32'h1122_3344;
      tick();
      check("p3_done_early", 32'(result_done), 32'd0);
      mem_data_C = 32'h5566_7788;
      tick();
      mem_write_en_C = 1'b0;
      check("p3_done_pulse", 32'(result_done), 32'd1);
      tick();
      check("p3_done_single", 32'(result_done), 32'd0);
      mem_write_en_C = 1'b1;
      mem_addr_C     = 10'h201;
      mem_data_C     = 32'h0000_0099;
      tick();
      mem_write_en_C = 1'b0;
      check("p3_no_second_done", 32'(result_done), 32'd0);
      acc_ready = 1'b1;
      tick();
      host_rd_chk("p3_c_last_wins", 10'h200, 32'h5566_7788);
      host_rd_chk("p3_c_excess_written", 10'h201, 32'h0000_0099);

      // ---------------- host stall, deferred grant, address sampled at grant ----------------
      acc_ready = 1'b0;
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 10'h200;
      acks      = 0;
      repeat (4) begin
         tick();
         if (host_ack) acks++;
      end
      check("p4_stall_no_ack", 32'(acks), 32'd0);
      acc_ready     = 1'b1;
      mem_read_en_B = 1'b1;
      mem_addr_B    = 10'h100;
      host_addr     = 10'h001;
      tick();
      mem_read_en_B = 1'b0;
      check("p4_grant_deferred", 32'(host_ack), 32'd0);
      tick();
      check("p4_ack", 32'(host_ack), 32'd1);
      check("p4_rdata_at_grant", host_rdata, 32'h0101_0101);
      host_req = 1'b0;
      tick();
      check("p4_rdata_held", host_rdata, 32'h0101_0101);

      // ---------------- out-of-window reads and sticky error ----------------
      mem_read_en_A = 1'b1;
      mem_addr_A    = 10'h100;
      tick();
      mem_read_en_A = 1'b0;
      check("p5_err_data", mem_data_A, ERR);
      check("p5_err_set", 32'(addr_err), 32'd1);
      tick();
      check("p5_err_sticky", 32'(addr_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("p5_err_cleared", 32'(addr_err), 32'd0);
      err_clr       = 1'b1;
      mem_read_en_A = 1'b1;
      tick();
      err_clr       = 1'b0;
      mem_read_en_A = 1'b0;
      check("p5_set_beats_clr", 32'(addr_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      host_rd_chk("p5_host_miss_data", 10'h300, ERR);
      check("p5_host_miss_err", 32'(addr_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr        = 1'b0;
      mem_write_en_C = 1'b1;
      mem_addr_C     = 10'h204;
      mem_data_C     = 32'h1234_5678;
      tick();
      mem_write_en_C = 1'b0;
      check("p5_c_miss_err", 32'(addr_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // ---------------- window decode table ----------------
      for (int i = 0; i < 4; i++) begin
         host_wr(10'(32'h000 + i), 32'hA0A0_0000 + 32'(i));
         host_wr(10'(32'h100 + i), 32'hB0B0_0000 + 32'(i));
      end
      vecs[0] = '{1'b0, 10'h000, 32'hA0A0_0000, 1'b0};
      vecs[1] = '{1'b0, 10'h003, 32'hA0A0_0003, 1'b0};
      vecs[2] = '{1'b0, 10'h004, ERR,           1'b1};
      vecs[3] = '{1'b1, 10'h0FF, ERR,           1'b1};
      vecs[4] = '{1'b1, 10'h100, 32'hB0B0_0000, 1'b0};
      vecs[5] = '{1'b1, 10'h103, 32'hB0B0_0003, 1'b0};
      vecs[6] = '{1'b1, 10'h104, ERR,           1'b1};
      vecs[7] = '{1'b0, 10'h3FF, ERR,           1'b1};
      vecs[8] = '{1'b0, 10'h002, 32'hA0A0_0002, 1'b0};
      vecs[9] = '{1'b1, 10'h001, ERR,           1'b1};
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].port_b) begin
            mem_read_en_B = 1'b1;
            mem_addr_B    = vecs[i].addr;
         end else begin
            mem_read_en_A = 1'b1;
            mem_addr_A    = vecs[i].addr;
         end
         tick();
         mem_read_en_A = 1'b0;
         mem_read_en_B = 1'b0;
         check($sformatf("tbl%0d_data", i), vecs[i].port_b ? mem_data_B : mem_data_A, vecs[i].exp_data);
         check($sformatf("tbl%0d_err", i), 32'(addr_err), 32'(vecs[i].exp_err));
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
      end

      // Simultaneous A and B reads are independent.
      mem_read_en_A = 1'b1;
      mem_addr_A    = 10'h001;
      mem_read_en_B = 1'b1;
      mem_addr_B    = 10'h102;
      tick();
      mem_read_en_A = 1'b0;
      mem_read_en_B = 1'b0;
      check("ab_same_cycle_A", mem_data_A, 32'hA0A0_0001);
      check("ab_same_cycle_B", mem_data_B, 32'hB0B0_0002);

      // ---------------- reset mid-transaction ----------------
      acc_ready = 1'b0;
      tick();
      mem_write_en_C = 1'b1;
      mem_addr_C     = 10'h202;
      mem_data_C     = 32'hCAFE_0001;
      tick();
      mem_write_en_C = 1'b0;
      host_req       = 1'b1;
      host_we        = 1'b0;
      host_addr      = 10'h000;
      tick();
      tick();
      #2;
      rstn = 1'b0;
      #1;
      check("p6_async_data_A", mem_data_A, 32'd0);
      check("p6_async_data_B", mem_data_B, 32'd0);
      check("p6_async_rdata", host_rdata, 32'd0);
      check("p6_async_ack", 32'(host_ack), 32'd0);
      check("p6_async_done", 32'(result_done), 32'd0);
      check("p6_async_err", 32'(addr_err), 32'd0);
      host_req = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      acks = 0;
      repeat (5) begin
         tick();
         if (host_ack) acks++;
      end
      check("p6_no_ack_after_reset", 32'(acks), 32'd0);
      mem_write_en_C = 1'b1;
      mem_addr_C     = 10'h203;
      mem_data_C     = 32'h7777_0000;
      tick();
      check("p6_cnt_cleared", 32'(result_done), 32'd0);
      tick();
      mem_write_en_C = 1'b0;
      check("p6_job_after_reset", 32'(result_done), 32'd1);
      acc_ready = 1'b1;
      tick();
      host_rd_chk("p6_bank_a_cleared", 10'h000, 32'd0);
      host_rd_chk("p6_bank_b_cleared", 10'h101, 32'd0);
      host_rd_chk("p6_bank_c_cleared", 10'h202, 32'd0);

      // ---------------- randomized run against the model ----------------
      clear_inputs();
      acc_ready = 1'b0;
      rstn      = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
         m_c[i] = '0;
      end
      m_da       = '0;
      m_db       = '0;
      m_rdata    = '0;
      m_err      = 1'b0;
      m_done     = 1'b0;
      m_acc_prev = 1'b0;
      m_cnt      = 0;
      m_h        = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (host_req && host_ack) begin
            host_req = 1'b0;
         end else if (!host_req) begin
            if ($urandom_range(0, 3) == 0) begin
               host_req   = 1'b1;
               host_we    = 1'($urandom_range(0, 1));
               host_addr  = rnd_addr();
               host_wdata = $urandom;
            end
         end else if ($urandom_range(0, 1) == 1) begin
            host_addr  = rnd_addr();
            host_wdata = $urandom;
         end
         if ($urandom_range(0, 7) == 0) acc_ready = ~acc_ready;
         mem_read_en_A  = ($urandom_range(0, 2) == 0);
         mem_addr_A     = rnd_addr();
         mem_read_en_B  = ($urandom_range(0, 2) == 0);
         mem_addr_B     = rnd_addr();
         mem_write_en_C = ($urandom_range(0, 3) == 0) && !(m_acc_prev && !acc_ready);
         mem_addr_C     = rnd_addr();
         mem_data_C     = $urandom;
         err_clr        = ($urandom_range(0, 5) == 0);
         model_step();
         tick();
         check($sformatf("rnd%0d_data_A", cyc), mem_data_A, m_da);
         check($sformatf("rnd%0d_data_B", cyc), mem_data_B, m_db);
         check($sformatf("rnd%0d_host_ack", cyc), 32'(host_ack), 32'(m_h == 2));
         check($sformatf("rnd%0d_host_rdata", cyc), host_rdata, m_rdata);
         check($sformatf("rnd%0d_result_done", cyc), 32'(result_done), 32'(m_done));
         check($sformatf("rnd%0d_addr_err", cyc), 32'(addr_err), 32'(m_err));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
